// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver.
// Frame shape depends on UART_RX_PARITY_EN (adds one even-parity bit).
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 417;
    localparam int unsigned DATA_BITS        = 8;

`ifdef UART_RX_PARITY_EN
    localparam int unsigned SAMPLE_BITS = DATA_BITS + 1;
    localparam int unsigned FRAME_BITS  = 11;
`else
    localparam int unsigned SAMPLE_BITS = DATA_BITS;
    localparam int unsigned FRAME_BITS  = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO holding received bytes.
// Head is presented on rd_data whenever the FIFO is non-empty, zero otherwise.
module rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/buffered_uart_rx.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO, with sticky error flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module buffered_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    output logic [7:0]               data_out,
    input  logic                     rd_en,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     parity_err,
    input  logic                     clr_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_SAMPLE = 4'(SAMPLE_BITS - 1);

    logic                   sync1_q;
    logic                   sync2_q;
    logic                   rx_s;
    state_t                 state_q;
    logic [CW-1:0]          clk_cnt_q;
    logic [3:0]             bit_cnt_q;
    logic [SAMPLE_BITS-1:0] shreg_q;
    logic                   push_q;
    logic                   ferr_evt_q;
    logic                   par_bad;
    logic                   fifo_full;
    logic                   ovr_evt;
    logic                   frame_err_q;
    logic                   frame_err_d;
    logic                   overrun_q;
    logic                   overrun_d;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = ^shreg_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            push_q     <= 1'b0;
            ferr_evt_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_evt_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shreg_q   <= {rx_s, shreg_q[SAMPLE_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_SAMPLE) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            push_q  <= ~par_bad;
                        end else begin
                            state_q    <= ST_WAIT_IDLE;
                            ferr_evt_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rx_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (shreg_q[7:0]),
        .rd_en   (rd_en),
        .rd_data (data_out),
        .empty   (empty),
        .full    (fifo_full),
        .count   (count)
    );

    assign full = fifo_full;

    // A new error event outranks a simultaneous clear.
    always_comb begin
        ovr_evt     = push_q & fifo_full & ~rd_en;
        frame_err_d = ferr_evt_q | (frame_err_q & ~clr_err);
        overrun_d   = ovr_evt | (overrun_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
    logic perr_evt_q;
    logic parity_err_q;
    logic parity_err_d;

    always_comb begin
        parity_err_d = perr_evt_q | (parity_err_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perr_evt_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_evt_q   <= (state_q == ST_STOP) && (clk_cnt_q == BIT_LAST)
                            && par_bad;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
